// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: decodes writer transactions on E falling edges, keeps a
// 2x16 character buffer, models busy timing and answers busy-flag/data reads.
module lcd_bus_responder #(
  parameter int BUSY_CYC = 800,
  parameter int HOME_CYC = 32800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_E,
  input  logic [7:0] DATA,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       busy,
  output logic [6:0] addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       id_inc,
  output logic       two_line,
  output logic       cmd_strobe,
  output logic       char_strobe,
  output logic [7:0] drop_cnt,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char
);

  localparam int MAXC = (HOME_CYC > BUSY_CYC) ? HOME_CYC : BUSY_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_BUSY} state_t;

  // Pin synchronizers, packed as {E, RS, RW, DATA}
  logic [10:0] pin_s1, pin_s2;
  logic        e_s, rs_s, rw_s, e_prev;
  logic [7:0]  d_s;
  logic        cap_rs, cap_rw;
  logic [7:0]  cap_d;
  logic        fall;

  assign e_s  = pin_s2[10];
  assign rs_s = pin_s2[9];
  assign rw_s = pin_s2[8];
  assign d_s  = pin_s2[7:0];
  assign fall = e_prev & ~e_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_s1 <= '0;
      pin_s2 <= '0;
      e_prev <= 1'b0;
      cap_rs <= 1'b0;
      cap_rw <= 1'b0;
      cap_d  <= '0;
    end else begin
      pin_s1 <= {LCD_E, LCD_RS, LCD_RW, DATA};
      pin_s2 <= pin_s1;
      e_prev <= e_s;
      if (e_s) begin
        cap_rs <= rs_s;
        cap_rw <= rw_s;
        cap_d  <= d_s;
      end
    end
  end

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic is_mapped(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  // Registered state
  state_t         state_reg, state_next;
  logic [4:0]     fill_idx_reg, fill_idx_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic           busy_reg;
  logic [6:0]     addr_reg, addr_next;
  logic           disp_reg, disp_next, cur_reg, cur_next, blink_reg, blink_next;
  logic           id_reg, id_next, two_reg, two_next;
  logic [7:0]     drop_reg, drop_next;
  logic           cmd_stb_reg, cmd_stb_next, char_stb_reg, char_stb_next;
  logic           mem_we;
  logic [4:0]     mem_wa;
  logic [7:0]     mem_wd;

  always_comb begin
    state_next    = state_reg;
    fill_idx_next = fill_idx_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    disp_next     = disp_reg;
    cur_next      = cur_reg;
    blink_next    = blink_reg;
    id_next       = id_reg;
    two_next      = two_reg;
    drop_next     = drop_reg;
    cmd_stb_next  = 1'b0;
    char_stb_next = 1'b0;
    mem_we        = 1'b0;
    mem_wa        = fill_idx_reg;
    mem_wd        = 8'h20;

    case (state_reg)
      S_FILL: begin
        mem_we        = 1'b1;
        fill_idx_next = fill_idx_reg + 5'd1;
        if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
        // Busy outlasts the fill whenever the clear delay is still running
        if (fill_idx_reg == 5'd31)
          state_next = (cnt_reg == '0) ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (cnt_reg == '0) state_next = S_IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: ;
    endcase

    if (fall) begin
      if (!cap_rw) begin
        if (busy_reg) begin
          if (drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;
        end else if (cap_rs) begin
          mem_we        = is_mapped(addr_reg);
          mem_wa        = {addr_reg[6], addr_reg[3:0]};
          mem_wd        = cap_d;
          addr_next     = step_addr(addr_reg, id_reg);
          char_stb_next = 1'b1;
          state_next    = S_BUSY;
          cnt_next      = CW'(BUSY_CYC - 1);
        end else begin
          cmd_stb_next = 1'b1;
          state_next   = S_BUSY;
          cnt_next     = CW'(BUSY_CYC - 1);
          if (cap_d[7]) begin
            addr_next = cap_d[6:0];
          end else if (cap_d[6]) begin
            // CGRAM address: not modelled, only busy
          end else if (cap_d[5]) begin
            two_next = cap_d[3];
          end else if (cap_d[4]) begin
            if (!cap_d[3]) addr_next = step_addr(addr_reg, cap_d[2]);
          end else if (cap_d[3]) begin
            disp_next  = cap_d[2];
            cur_next   = cap_d[1];
            blink_next = cap_d[0];
          end else if (cap_d[2]) begin
            id_next = cap_d[1];
          end else if (cap_d[1]) begin
            addr_next = 7'h00;
            cnt_next  = CW'(HOME_CYC - 1);
          end else if (cap_d[0]) begin
            addr_next     = 7'h00;
            id_next       = 1'b1;
            state_next    = S_FILL;
            fill_idx_next = 5'd0;
            cnt_next      = CW'(HOME_CYC - 1);
          end
        end
      end else if (cap_rs && !busy_reg) begin
        addr_next = step_addr(addr_reg, id_reg);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FILL;
      fill_idx_reg <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b1;
      addr_reg     <= '0;
      disp_reg     <= 1'b0;
      cur_reg      <= 1'b0;
      blink_reg    <= 1'b0;
      id_reg       <= 1'b1;
      two_reg      <= 1'b0;
      drop_reg     <= '0;
      cmd_stb_reg  <= 1'b0;
      char_stb_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_idx_reg <= fill_idx_next;
      cnt_reg      <= cnt_next;
      busy_reg     <= (state_next != S_IDLE);
      addr_reg     <= addr_next;
      disp_reg     <= disp_next;
      cur_reg      <= cur_next;
      blink_reg    <= blink_next;
      id_reg       <= id_next;
      two_reg      <= two_next;
      drop_reg     <= drop_next;
      cmd_stb_reg  <= cmd_stb_next;
      char_stb_reg <= char_stb_next;
    end
  end

  // Character buffer: one write port, two registered read ports
  logic [7:0] mem [0:31];
  logic [7:0] rd_char_reg, bus_q_reg;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    rd_char_reg <= mem[rd_idx];
    bus_q_reg   <= mem[{addr_reg[6], addr_reg[3:0]}];
  end

  logic oe_reg, out_rs_reg, out_map_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_reg      <= 1'b0;
      out_rs_reg  <= 1'b0;
      out_map_reg <= 1'b0;
    end else begin
      oe_reg      <= e_s & rw_s;
      out_rs_reg  <= rs_s;
      out_map_reg <= is_mapped(addr_reg);
    end
  end

  assign DATA_OE     = oe_reg;
  assign DATA_OUT    = out_rs_reg ? (out_map_reg ? bus_q_reg : 8'h20) : {busy_reg, addr_reg};
  assign busy        = busy_reg;
  assign addr        = addr_reg;
  assign disp_on     = disp_reg;
  assign cursor_on   = cur_reg;
  assign blink_on    = blink_reg;
  assign id_inc      = id_reg;
  assign two_line    = two_reg;
  assign cmd_strobe  = cmd_stb_reg;
  assign char_strobe = char_stb_reg;
  assign drop_cnt    = drop_reg;
  assign rd_char     = rd_char_reg;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder: strobe and buffer-read expectations are queued
// by the stimulus and checked by an independent monitor.
`timescale 1ns/1ps
module tb_lcd_bus_responder;
  localparam int BUSY = 50;
  localparam int HOME = 200;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_E = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic [4:0] rd_idx = 5'd0;
  logic [7:0] DATA_OUT, drop_cnt, rd_char;
  logic       DATA_OE, busy, disp_on, cursor_on, blink_on, id_inc, two_line;
  logic       cmd_strobe, char_strobe;
  logic [6:0] addr;

  lcd_bus_responder #(.BUSY_CYC(BUSY), .HOME_CYC(HOME)) dut (
    .clk(clk), .rst_n(rst_n), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_E(LCD_E),
    .DATA(DATA), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .busy(busy), .addr(addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .id_inc(id_inc),
    .two_line(two_line), .cmd_strobe(cmd_strobe), .char_strobe(char_strobe),
    .drop_cnt(drop_cnt), .rd_idx(rd_idx), .rd_char(rd_char)
  );

  always #25 clk = ~clk;

  typedef struct packed {
    logic       ch;
    logic [6:0] addr;
    logic [4:0] flags;   // {disp, cursor, blink, id_inc, two_line}
    logic [7:0] drop;
  } stb_t;

  stb_t       stb_q[$];
  logic [7:0] rd_q[$];
  int         checks = 0, failures = 0;
  logic       rd_req = 1'b0, rd_val_d = 1'b0;
  stb_t       mon_exp, mon_act;
  logic [7:0] mon_rd;
  logic [4:0] flags_now;

  assign flags_now = {disp_on, cursor_on, blink_on, id_inc, two_line};

  always @(posedge clk) rd_val_d <= rd_req;

  // Monitor: pops the scoreboard whenever the DUT presents a strobe or read data
  always @(negedge clk) begin
    if (rd_val_d) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%02h", rd_char);
      end else begin
        mon_rd = rd_q.pop_front();
        if (rd_char !== mon_rd) begin
          failures++;
          $display("FAIL rd_char got=%02h exp=%02h", rd_char, mon_rd);
        end
      end
    end
    if (cmd_strobe || char_strobe) begin
      checks++;
      mon_act = {char_strobe, addr, flags_now, drop_cnt};
      if (stb_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected got=%06h", mon_act);
      end else begin
        mon_exp = stb_q.pop_front();
        if ((cmd_strobe && char_strobe) || mon_act !== mon_exp) begin
          failures++;
          $display("FAIL strobe got=%06h exp=%06h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = rw; DATA = d;
    @(negedge clk);
    LCD_E = 1'b1;
    repeat (4) @(negedge clk);
    LCD_E = 1'b0;
    repeat (3) @(negedge clk);
    LCD_RW = 1'b0;
    $display("bus write rs=%0b data=%02h addr=%02h busy=%0b", rs, d, addr, busy);
  endtask

  task automatic cmd(input logic [7:0] d, input logic [6:0] ea, input logic [4:0] ef, input logic [7:0] ed);
    stb_q.push_back({1'b0, ea, ef, ed});
    bus(1'b0, 1'b0, d);
  endtask

  task automatic chr(input logic [7:0] d, input logic [6:0] ea, input logic [4:0] ef, input logic [7:0] ed);
    stb_q.push_back({1'b1, ea, ef, ed});
    bus(1'b1, 1'b0, d);
  endtask

  task automatic bus_read(input logic rs, input logic [7:0] exp);
    @(negedge clk);
    LCD_RS = rs; LCD_RW = 1'b1;
    @(negedge clk);
    LCD_E = 1'b1;
    repeat (4) @(negedge clk);
    $display("bus read rs=%0b data_out=%02h oe=%0b", rs, DATA_OUT, DATA_OE);
    check("read_oe_high", DATA_OE, 1'b1);
    check("read_data", DATA_OUT, exp);
    LCD_E = 1'b0;
    repeat (4) @(negedge clk);
    check("read_oe_low", DATA_OE, 1'b0);
    LCD_RW = 1'b0; LCD_RS = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < HOME + 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_bounded", busy, 1'b0);
  endtask

  task automatic rd_buf(input logic [4:0] idx, input logic [7:0] exp);
    @(negedge clk);
    rd_idx = idx;
    rd_req = 1'b1;
    rd_q.push_back(exp);
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd_all_spaces();
    for (int i = 0; i < 32; i++) rd_buf(5'(i), 8'h20);
    rd_end();
  endtask

  initial begin
    #(60000 * 50);
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_addr", addr, 7'h00);
    check("rst_flags", flags_now, 5'b00010);
    check("rst_drop", drop_cnt, 8'h00);
    check("rst_oe", DATA_OE, 1'b0);
    rst_n = 1'b1;
    wait_idle(n);
    check("init_fill_busy", n, 32);
    rd_all_spaces();

    // Configuration commands
    cmd(8'h38, 7'h00, 5'b00011, 8'd0); wait_idle(n);
    check("busy_cyc", n, BUSY);
    cmd(8'h0E, 7'h00, 5'b11011, 8'd0); wait_idle(n);
    cmd(8'h06, 7'h00, 5'b11011, 8'd0); wait_idle(n);

    // Text on both lines
    chr(8'h48, 7'h01, 5'b11011, 8'd0); wait_idle(n);
    chr(8'h49, 7'h02, 5'b11011, 8'd0); wait_idle(n);
    cmd(8'hC0, 7'h40, 5'b11011, 8'd0); wait_idle(n);
    chr(8'h5A, 7'h41, 5'b11011, 8'd0); wait_idle(n);
    rd_buf(5'd0, 8'h48); rd_buf(5'd1, 8'h49); rd_buf(5'd16, 8'h5A); rd_buf(5'd2, 8'h20);
    rd_end();

    // Write while busy is dropped
    cmd(8'h14, 7'h42, 5'b11011, 8'd0);
    bus(1'b1, 1'b0, 8'h41);
    wait_idle(n);
    check("drop_cnt", drop_cnt, 8'd1);
    check("drop_addr", addr, 7'h42);
    rd_buf(5'd18, 8'h20); rd_end();

    // Busy-flag read, 0x27 -> 0x40 wrap, unmapped store
    cmd(8'hA7, 7'h27, 5'b11011, 8'd1);
    bus_read(1'b0, 8'hA7);
    wait_idle(n);
    bus_read(1'b0, 8'h27);
    chr(8'h51, 7'h40, 5'b11011, 8'd1); wait_idle(n);
    rd_buf(5'd16, 8'h5A); rd_end();

    // Decrement mode and left-moving wraps
    cmd(8'h04, 7'h40, 5'b11001, 8'd1); wait_idle(n);
    chr(8'h41, 7'h27, 5'b11001, 8'd1); wait_idle(n);
    cmd(8'h10, 7'h26, 5'b11001, 8'd1); wait_idle(n);
    cmd(8'h80, 7'h00, 5'b11001, 8'd1); wait_idle(n);
    cmd(8'h10, 7'h67, 5'b11001, 8'd1); wait_idle(n);
    cmd(8'h06, 7'h67, 5'b11011, 8'd1); wait_idle(n);
    chr(8'h58, 7'h00, 5'b11011, 8'd1); wait_idle(n);
    rd_buf(5'd16, 8'h41); rd_end();

    // Data read steps the cursor
    cmd(8'h80, 7'h00, 5'b11011, 8'd1); wait_idle(n);
    bus_read(1'b1, 8'h48);
    check("data_read_addr", addr, 7'h01);

    // Return home and clear
    cmd(8'h02, 7'h00, 5'b11011, 8'd1); wait_idle(n);
    check("home_busy", n, HOME);
    cmd(8'h01, 7'h00, 5'b11011, 8'd1); wait_idle(n);
    check("clear_busy", n, HOME);
    check("clear_addr", addr, 7'h00);
    rd_all_spaces();

    // Reset in the middle of a clear-triggered fill
    chr(8'h48, 7'h01, 5'b11011, 8'd1); wait_idle(n);
    cmd(8'h01, 7'h00, 5'b11011, 8'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_flags", flags_now, 5'b00010);
    check("rst2_drop", drop_cnt, 8'h00);
    check("rst2_busy", busy, 1'b1);
    rst_n = 1'b1;
    wait_idle(n);
    check("refill_busy", n, 32);
    rd_all_spaces();

    repeat (5) @(negedge clk);
    check("stb_q_empty", stb_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

HD44780-compatible responder for the 8-bit parallel LCD bus driven by the team's LCD writer blocks. It samples LCD_RS/LCD_RW/LCD_E/DATA from the pins, decodes commands and character writes on each E falling edge, and keeps a 2×16 display buffer with a cursor address and busy timing. It answers busy-flag reads, so writer RTL can be checked on the bench and on the board without a physical panel. The buffer has a registered read port for a monitor or UART dump.

## Interface
- BUSY_CYC, 800: busy duration after any non-clear/home instruction or data write (40 µs at 20 MHz).
- HOME_CYC, 32800: busy duration after clear display or return home (1.64 ms at 20 MHz).
- clk  in  1  system clock, 20 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- LCD_RS  in  1  register select from the writer: 0 = instruction, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_E  in  1  enable strobe, asynchronous to clk.
- DATA  in  8  bus data from the writer.
- DATA_OUT  out  8  read data, {busy, addr[6:0]}.
- DATA_OE  out  1  bus drive enable for DATA_OUT.
- busy  out  1  internal busy flag.
- addr  out  7  current DDRAM address (cursor).
- disp_on, cursor_on, blink_on  out  1 each  display-control flags (D, C, B).
- id_inc  out  1  entry-mode I/D: 1 = increment, 0 = decrement.
- two_line  out  1  function-set N bit.
- cmd_strobe  out  1  one-cycle pulse when an accepted instruction executes.
- char_strobe  out  1  one-cycle pulse when an accepted data byte is written.
- drop_cnt  out  8  count of writes received while busy; saturates at 255.
- rd_idx  in  5  buffer read index: 0–15 = line 1, 16–31 = line 2.
- rd_char  out  8  buffer byte at rd_idx, one-cycle registered latency.

## Operation
- LCD_E, LCD_RS, LCD_RW and DATA pass through 2-flop synchronizers.
- While synced E = 1, the RS/RW/DATA sample is captured every cycle. The last captured sample is the transaction.
- Falling edge of synced E (previous sample 1, current 0) = transaction end, the "fall cycle".
- States:
  - FILL: writes 0x20 into entry fill_idx, fill_idx++. Moves to IDLE after entry 31.
  - IDLE: waits for a transaction.
  - BUSY: busy counter decrements to 0, then returns to IDLE.
- Async reset sets state = FILL, fill_idx = 0, busy = 1. All flags = 0 except id_inc = 1. addr = 0, drop_cnt = 0, strobes = 0, DATA_OE = 0.
- On a write transaction (RW = 0) while busy = 1:
  - the transaction is ignored;
  - drop_cnt increments (saturating);
  - no strobe is asserted.
- Instruction decode (RS = 0, RW = 0, not busy), highest set bit wins:
  - 0x80+: addr = DATA[6:0].
  - 0x20–0x3F: two_line = DATA[3]. DL and F are ignored.
  - 0x10–0x1F: if DATA[3] = 0, the cursor moves by one (DATA[2] = 1 right, 0 left) using the wrap rules. Display shift is ignored.
  - 0x08–0x0F: disp_on = DATA[2], cursor_on = DATA[1], blink_on = DATA[0].
  - 0x04–0x07: id_inc = DATA[1]. S is ignored.
  - 0x02–0x03: addr = 0. Busy uses HOME_CYC.
  - 0x01: addr = 0, id_inc = 1, then state FILL. Busy uses HOME_CYC, counted from the fall cycle and concurrent with the fill.
  - 0x00: no effect, but still busy for BUSY_CYC.
- Data write (RS = 1, RW = 0, not busy):
  - byte stored at the buffer index mapped from addr;
  - addr steps by ±1 per id_inc;
  - char_strobe pulses.
- Buffer mapping: addr 0x00–0x0F → index 0–15, addr 0x40–0x4F → index 16–31. Other addresses store nothing but still step.
- Address wrap:
  - increment 0x27 → 0x40, 0x67 → 0x00;
  - decrement 0x00 → 0x67, 0x40 → 0x27;
  - set-address values outside 0x00–0x27 and 0x40–0x67 are stored as given.
- Busy-flag read (RS = 0, RW = 1):
  - DATA_OE = 1 and DATA_OUT = {busy, addr} while synced E = 1;
  - both are reevaluated every cycle;
  - no state change.
- Data read (RS = 1, RW = 1): DATA_OE = 1, DATA_OUT = buffer byte at addr (0x20 if unmapped). addr steps on the fall cycle. Not counted when busy.

## Timing
- Fall cycle is 3 clk after the pin E falls.
- Register updates and strobes are registered and appear 1 cycle after the fall cycle.
- busy rises in that same cycle and stays high for exactly BUSY_CYC or HOME_CYC cycles.
- FILL takes 32 cycles; busy stays high for max(32, HOME_CYC) cycles.
- After reset release, busy falls 32 cycles later.
- Minimum E high / low width: 2 clk each; shorter pulses are unsupported.
- DATA_OE drops 1 cycle after synced E falls.
- rd_char is valid 1 cycle after rd_idx changes. During FILL it returns the current (stale or space) content.
- Reset mid-FILL or mid-BUSY aborts the operation and restarts FILL from index 0.
- Transaction on the fall cycle that busy reaches 0: still treated as busy (dropped).

## Test plan
- Reset release, no bus activity → busy high 32 cycles then low; rd_idx 0..31 all read 0x20; addr = 0.
- Writes 0x38, 0x0E, 0x06, each followed by wait > BUSY_CYC → two_line = 1, disp_on = 1, cursor_on = 1, blink_on = 0, id_inc = 1; 3 cmd_strobe pulses.
- Data writes 'H', 'I', then 0xC0, then 'Z' → rd_char[0] = 0x48, [1] = 0x49, [16] = 0x5A; addr = 0x41.
- Write 0x41 immediately after a command (within BUSY_CYC) → buffer unchanged, drop_cnt = 1, no char_strobe.
- Busy read during BUSY after 0xA7 → DATA_OE = 1, DATA_OUT = 0xA7. After the delay, the read gives 0x27. A data write then moves addr to 0x40.
- 0x01 after text → busy ≈ HOME_CYC, all 32 entries 0x20, addr = 0. Reset asserted mid-fill → fill restarts; all spaces after 32 cycles.
